// File: rtl/tmac_uni_param.sv
// tmac_uni_param: parametrised unipolar temporal multiply-accumulate unit.
// Each channel turns its latched A operand into a stochastic stream by
// comparing it against a shared RNG word, and gates that stream with a unary
// time window of length B. Per-channel ones-counts are summed by a two-stage
// adder tree. The total is then either saturated or scaled by 1/NUM_CH.
// The result is presented as a binary word and as a unipolar bitstream.
module tmac_uni_param #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 16,
    parameter int SCALED = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH*WIDTH-1:0] iA,
    input  logic [NUM_CH*WIDTH-1:0] iB,
    input  logic [WIDTH-1:0]        rngA,
    input  logic [WIDTH-1:0]        rngC,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        oRes,
    output logic                    oSat,
    output logic                    oC
);

    // Derived widths: each quarter of the tree sums NUM_CH/4 counters, and the
    // final total needs log2(NUM_CH) bits of headroom over a single counter.
    localparam int LOG_CH  = $clog2(NUM_CH);
    localparam int QUARTER = NUM_CH / 4;
    localparam int PW      = WIDTH + LOG_CH - 2;
    localparam int TW      = WIDTH + LOG_CH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM1 = 2'd2,
        SUM2 = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  t_q, t_d;
    logic [WIDTH-1:0]  a_q   [NUM_CH];
    logic [WIDTH-1:0]  a_d   [NUM_CH];
    logic [WIDTH-1:0]  b_q   [NUM_CH];
    logic [WIDTH-1:0]  b_d   [NUM_CH];
    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_d [NUM_CH];
    logic [PW-1:0]     part_q [4];
    logic [PW-1:0]     part_d [4];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              sat_q, sat_d;

    logic [NUM_CH-1:0] prod;
    logic [PW-1:0]     part_sum [4];
    logic [TW-1:0]     total;
    logic [WIDTH-1:0]  res_next;
    logic              sat_next;

    // Per-channel product bit: inside the B-cycle window and A beats the RNG.
    always_comb begin
        prod = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            prod[i] = (t_q < b_q[i]) && (a_q[i] > rngA);
        end
    end

    // First adder-tree stage: four partial sums over consecutive channel groups.
    always_comb begin
        part_sum = '{default: '0};
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < QUARTER; j++) begin
                part_sum[g] = part_sum[g] + PW'(cnt_q[g*QUARTER + j]);
            end
        end
    end

    // Second adder-tree stage plus result shaping (saturate or divide by NUM_CH).
    always_comb begin
        total = TW'(part_q[0]) + TW'(part_q[1]) + TW'(part_q[2]) + TW'(part_q[3]);
        if (SCALED != 0) begin
            res_next = total[TW-1:LOG_CH];
            sat_next = 1'b0;
        end else begin
            sat_next = |total[TW-1:WIDTH];
            res_next = sat_next ? {WIDTH{1'b1}} : total[WIDTH-1:0];
        end
    end

    // Next-state logic for the run sequencer and all datapath registers.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    t_d     = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        a_d[i]   = iA[i*WIDTH +: WIDTH];
                        b_d[i]   = iB[i*WIDTH +: WIDTH];
                        cnt_d[i] = '0;
                    end
                end
            end

            RUN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(prod[i]);
                end
                t_d = t_q + WIDTH'(1);
                if (t_q == {WIDTH{1'b1}}) begin
                    state_d = SUM1;
                end
            end

            SUM1: begin
                part_d  = part_sum;
                state_d = SUM2;
            end

            SUM2: begin
                res_d   = res_next;
                sat_d   = sat_next;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register: asynchronous active-low reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                cnt_q[i] <= '0;
            end
            for (int g = 0; g < 4; g++) begin
                part_q[g] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign oRes = res_q;
    assign oSat = sat_q;
    assign oC   = (res_q > rngC);

endmodule

// File: tb/tb_tmac_uni_param.sv
// Testbench for tmac_uni_param: one saturating and one scaled instance share
// the same stimulus and are compared every cycle against a behavioural model.
module tb_tmac_uni_param;

    localparam int W      = 8;
    localparam int N      = 16;
    localparam int RUNLEN = 1 << W;
    localparam int LAT    = RUNLEN + 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] iA    = '0;
    logic [N*W-1:0] iB    = '0;
    logic [W-1:0]   rngA  = '0;
    logic [W-1:0]   rngC  = '0;

    logic           busy0, done0, sat0, c0;
    logic [W-1:0]   res0;
    logic           busy1, done1, sat1, c1;
    logic [W-1:0]   res1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit ramp_mode = 1'b0;
    bit rand_c    = 1'b1;

    tmac_uni_param #(.WIDTH(W), .NUM_CH(N), .SCALED(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .iA(iA), .iB(iB),
        .rngA(rngA), .rngC(rngC), .busy(busy0), .done(done0),
        .oRes(res0), .oSat(sat0), .oC(c0)
    );

    tmac_uni_param #(.WIDTH(W), .NUM_CH(N), .SCALED(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .iA(iA), .iB(iB),
        .rngA(rngA), .rngC(rngC), .busy(busy1), .done(done1),
        .oRes(res1), .oSat(sat1), .oC(c1)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: remember operands and the RNG sequence of a run,
    // then count product ones directly from the definition.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_sat0 = 1'b0;
    logic [W-1:0] m_res0 = '0;
    logic [W-1:0] m_res1 = '0;
    int           m_cyc  = 0;
    logic [W-1:0] m_a  [N];
    logic [W-1:0] m_b  [N];
    logic [W-1:0] hist [RUNLEN];

    function automatic int modelTotal();
        int tot = 0;
        for (int ch = 0; ch < N; ch++) begin
            for (int t = 0; t < RUNLEN; t++) begin
                if ((t < int'(m_b[ch])) && (m_a[ch] > hist[t])) tot++;
            end
        end
        return tot;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sat0 <= 1'b0;
            m_res0 <= '0;
            m_res1 <= '0;
            m_cyc  <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_cyc  <= 0;
                    for (int ch = 0; ch < N; ch++) begin
                        m_a[ch] <= iA[ch*W +: W];
                        m_b[ch] <= iB[ch*W +: W];
                    end
                end
            end else begin
                m_cyc <= m_cyc + 1;
                if (m_cyc < RUNLEN) hist[m_cyc] <= rngA;
                if (m_cyc == LAT - 1) begin
                    m_sat0 <= (modelTotal() > RUNLEN - 1);
                    m_res0 <= (modelTotal() > RUNLEN - 1) ? W'(RUNLEN - 1) : W'(modelTotal());
                    m_res1 <= W'(modelTotal() / N);
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        checkOutput("busy0", busy0, m_busy);
        checkOutput("done0", done0, m_done);
        checkOutput("oRes0", res0, m_res0);
        checkOutput("oSat0", sat0, m_sat0);
        checkOutput("oC0",   c0,   (m_res0 > rngC));
        checkOutput("busy1", busy1, m_busy);
        checkOutput("done1", done1, m_done);
        checkOutput("oRes1", res1, m_res1);
        checkOutput("oSat1", sat1, 0);
        checkOutput("oC1",   c1,   (m_res1 > rngC));
    end

    // One clock step; inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (ramp_mode && m_busy) rngA = W'(m_cyc);
        else                     rngA = W'($urandom);
        if (rand_c) rngC = W'($urandom);
    endtask

    task automatic applyStimulus(input int a_mode, input int b_mode);
        for (int ch = 0; ch < N; ch++) begin
            case (a_mode)
                0: iA[ch*W +: W] = W'(8'h10);
                1: iA[ch*W +: W] = (ch == 0) ? W'(8'hFF) : W'(0);
                default: iA[ch*W +: W] = W'($urandom);
            endcase
            case (b_mode)
                0: iB[ch*W +: W] = W'(8'h10);
                1: iB[ch*W +: W] = (ch == 0) ? W'(8'h80) : W'(0);
                2: iB[ch*W +: W] = W'($urandom_range(0, 40));
                default: iB[ch*W +: W] = W'($urandom);
            endcase
        end
    endtask

    task automatic startRun(output int k);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc;
    endtask

    task automatic waitDone(input int k, input string tag);
        int n = 0;
        while (n < LAT + 20) begin
            @(negedge clk);
            if (done0 === 1'b1) break;
            n++;
        end
        if (done0 === 1'b1) checkOutput({tag, "_latency"}, cyc - k, LAT);
        else                checkOutput({tag, "_timeout"}, 0, 1);
    endtask

    task automatic holdC(input logic [W-1:0] v);
        rand_c = 1'b0;
        tick();
        rngC = v;
        @(negedge clk);
    endtask

    initial begin
        int k;
        int ndone;

        // Reset held while inputs toggle.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'($urandom);
            applyStimulus(2, 3);
            @(negedge clk);
            checkOutput("rst_busy", busy0, 0);
            checkOutput("rst_done", done0, 0);
            checkOutput("rst_oRes", res0, 0);
            checkOutput("rst_oSat", sat0, 0);
            checkOutput("rst_oC",   c0,   0);
        end
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        checkOutput("idle_busy", busy0, 0);

        // Uniform 0x10 operands with a ramp RNG: saturating vs scaled.
        ramp_mode = 1'b1;
        applyStimulus(0, 0);
        startRun(k);
        waitDone(k, "uniform");
        checkOutput("uniform_oRes0", res0, 255);
        checkOutput("uniform_oSat0", sat0, 1);
        checkOutput("uniform_oRes1", res1, 16);
        checkOutput("uniform_oSat1", sat1, 0);
        holdC(8'd15);
        checkOutput("uniform_oC1_c15", c1, 1);
        holdC(8'd16);
        checkOutput("uniform_oC1_c16", c1, 0);
        rand_c = 1'b1;
        repeat (3) tick();

        // Only channel 0 active.
        applyStimulus(1, 1);
        startRun(k);
        waitDone(k, "ch0");
        checkOutput("ch0_oRes0", res0, 128);
        checkOutput("ch0_oSat0", sat0, 0);
        checkOutput("ch0_oRes1", res1, 8);
        holdC(8'd127);
        checkOutput("ch0_oC0_c127", c0, 1);
        holdC(8'd128);
        checkOutput("ch0_oC0_c128", c0, 0);
        rand_c = 1'b1;
        repeat (3) tick();

        // start pulse and operand changes in the middle of a run.
        ramp_mode = 1'b0;
        applyStimulus(2, 2);
        startRun(k);
        repeat (50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(2, 3);
        ndone = 0;
        for (int n = 0; n < LAT; n++) begin
            tick();
            @(negedge clk);
            if (done0 === 1'b1) ndone++;
        end
        checkOutput("midrun_single_done", ndone, 1);

        // Back-to-back: start during the done cycle.
        applyStimulus(2, 2);
        startRun(k);
        waitDone(k, "b2b_first");
        applyStimulus(2, 3);
        startRun(k);
        @(negedge clk);
        checkOutput("b2b_busy", busy0, 1);
        waitDone(k, "b2b_second");
        repeat (3) tick();

        // Reset at RUN cycle 100: abort, no done, then a clean restart.
        ramp_mode = 1'b1;
        applyStimulus(0, 0);
        startRun(k);
        repeat (100) tick();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_oRes", res0, 0);
        checkOutput("abort_oSat", sat0, 0);
        checkOutput("abort_oC",   c0,   0);
        repeat (3) tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < LAT + 20; n++) begin
            tick();
            @(negedge clk);
            if (done0 === 1'b1) ndone++;
        end
        checkOutput("abort_no_done", ndone, 0);
        startRun(k);
        waitDone(k, "restart");
        checkOutput("restart_oRes0", res0, 255);

        // Randomised runs, some back-to-back.
        ramp_mode = 1'b0;
        for (int r = 0; r < 8; r++) begin
            applyStimulus(2, (r % 2 == 0) ? 2 : 3);
            startRun(k);
            waitDone(k, "random");
            if (r % 3 != 0) repeat ($urandom_range(1, 5)) tick();
        end
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit so the bench always terminates.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmac_uni_param.md
Name: tmac_uni_param

Overview:
- Parametrised unipolar temporal multiply-accumulate unit. Replaces the fixed 16-channel, 8-bit MAC.
- Takes NUM_CH operand pairs. Each channel multiplies temporally: A is compared against an external RNG, B is a unary time window.
- Per-channel product counts are summed in a 2-stage pipelined adder tree. The sum is then either saturated (non-scaled) or divided by NUM_CH (scaled).
- Results are a binary value plus a unipolar output bitstream.
- Adds a start/busy/done handshake. RNG sequences come from shared generators outside the block.

Parameters:
- WIDTH, 8, operand/RNG/result bit width; one run lasts 2^WIDTH cycles.
- NUM_CH, 16, channel count; power of 2, at least 4.
- SCALED, 0, 0 = saturating sum clipped to 2^WIDTH-1; 1 = sum right-shifted by log2(NUM_CH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a run; sampled only in IDLE
- iA  in  NUM_CH x WIDTH  multiplicand per channel (probability A/2^WIDTH)
- iB  in  NUM_CH x WIDTH  multiplier per channel (temporal length B cycles)
- rngA  in  WIDTH  shared RNG word for the product streams; sampled every RUN cycle
- rngC  in  WIDTH  RNG word for output stream generation
- busy  out  1  high from start acceptance until result write
- done  out  1  one-cycle pulse, result valid
- oRes  out  WIDTH  registered MAC result; holds until next result write
- oSat  out  1  registered; 1 if the last non-scaled result clipped (always 0 when SCALED=1)
- oC  out  1  output bitstream, oC = (oRes > rngC), combinational

Behaviour:
- Reset values: all state cleared to IDLE; busy=0, done=0, oRes=0, oSat=0; internal counters, latched operands and partial sums all 0. Hence oC=0.
- FSM states: IDLE, RUN, SUM1, SUM2.
  - IDLE to RUN: at edge k with start=1. On that edge: latch iA/iB into internal registers, clear all channel counters, set t=0, set busy=1.
  - RUN: lasts exactly 2^WIDTH edges (k+1..k+2^WIDTH), using t=0..2^WIDTH-1.
    - Each edge: cnt_i += p_i, where p_i = (t < Bq_i) AND (Aq_i > rngA).
    - t increments every edge. Leave RUN on the edge where t = 2^WIDTH-1.
  - SUM1 (edge k+2^WIDTH+1): register 4 partial sums, each over NUM_CH/4 consecutive channels. Width WIDTH+log2(NUM_CH)-2.
  - SUM2 (edge k+2^WIDTH+2): compute total = sum of the 4 partials, width WIDTH+log2(NUM_CH). Then write oRes:
    - SCALED=0: oRes = min(total, 2^WIDTH-1); oSat = (total > 2^WIDTH-1).
    - SCALED=1: oRes = total >> log2(NUM_CH); oSat = 0.
    - Same edge: done=1, busy=0, state to IDLE.
- Channel counters are WIDTH bits wide and cannot overflow, since p_i is 1 at most Bq_i ≤ 2^WIDTH-1 times.
- done is high for exactly one cycle after the SUM2 edge.
- start=1 during the done cycle is accepted (back-to-back runs with no idle gap).
- Latency: start sampled at edge k; done high after edge k+2^WIDTH+2. Busy lasts 2^WIDTH+2 cycles.
- start while busy is ignored, with no queueing.
- iA/iB changes after the latch edge have no effect on the current run.
- oRes/oSat hold their value throughout later runs until the next SUM2 edge. oC keeps streaming the old result during a run.
- rngC is unused except by oC. rngA is ignored outside RUN.
- rst_n asserted mid-run: immediate abort, every register returns to its reset value, and no done is issued. The first start after release behaves normally.

Test Plan:
- Reset: hold rst_n=0, toggle inputs -> busy=done=oRes=oSat=oC=0. Release, no start -> stays IDLE indefinitely.
- WIDTH=8, NUM_CH=16, SCALED=0, all iA=iB=0x10, rngA=t ramp (so cnt_i = min(A_i,B_i) = 16) -> total 256, oRes=255, oSat=1, done exactly 258 cycles after the start edge.
- Same stimulus, SCALED=1 -> oRes=16, oSat=0. With rngC=15 -> oC=1; with rngC=16 -> oC=0.
- Only channel 0 active: iA[0]=0xFF, iB[0]=0x80, all others 0, ramp rngA, SCALED=0 -> oRes=128, oSat=0. rngC=127 gives oC=1; rngC=128 gives oC=0.
- Handshake:
  - Pulse start mid-RUN, change iA/iB mid-RUN -> single done; result matches the latched operands.
  - start=1 in the done cycle -> new run begins with busy=1 the next cycle; second done 258 cycles later.
- Reset at RUN cycle 100 -> all outputs 0, no done. Fresh start afterwards with the scenario-2 stimulus -> oRes=255 at the expected cycle.
